// File: rtl/pg_table_loader_pkg.sv
// Shared types for the port-group rule tables and the table loader.
// Widths here size the rule-to-PG table address and entry.
package pg_table_loader_pkg;

   localparam int RULE_AWIDTH   = 10;
   localparam int RULE_PG_WIDTH = 16;

   typedef struct packed {
      logic [7:0]  port;
      logic [15:0] len;
      logic        sop;
      logic        eop;
   } metadata_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2,
      WRITE = 2'd3
   } pg_loader_state_t;

endpackage

// File: rtl/pg_table_loader.sv
// Quiesces the port-group metadata path, then streams a batch of table
// entries into the rule-to-PG table one per cycle before reopening traffic.
module pg_table_loader #(
   parameter int DRAIN_CYCLES  = 20,
   parameter int RULE_AWIDTH   = pg_table_loader_pkg::RULE_AWIDTH,
   parameter int RULE_PG_WIDTH = pg_table_loader_pkg::RULE_PG_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [RULE_AWIDTH-1:0]   cfg_addr,
   input  logic [RULE_PG_WIDTH-1:0] cfg_data,
   input  logic                     cfg_last,
   input  logic                     up_meta_valid,
   output logic                     up_meta_ready,
   output logic                     dn_meta_valid,
   input  logic                     dn_meta_ready,
   output logic [RULE_PG_WIDTH-1:0] wr_data,
   output logic [RULE_AWIDTH-1:0]   wr_addr,
   output logic                     wr_en,
   output logic                     busy,
   output logic [31:0]              write_cnt,
   output logic [31:0]              stall_cnt
);
   import pg_table_loader_pkg::*;

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   pg_loader_state_t state, state_nxt;
   logic [DCW-1:0]   drain_cnt;
   logic             meta_busy;
   logic             gate;
   logic             meta_hs;
   logic             cfg_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // HOLD only leaves once no meta is in flight and none completes this cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (cfg_valid) state_nxt = HOLD;
         HOLD:    if (!meta_busy && !meta_hs) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == '0) state_nxt = WRITE;
         WRITE:   if (cfg_hs && cfg_last) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      cfg_ready     = (state == WRITE);
      busy          = (state != RUN);
      gate          = (state == RUN) || meta_busy;
      dn_meta_valid = up_meta_valid && gate;
      up_meta_ready = dn_meta_ready && gate;
      meta_hs       = dn_meta_valid && dn_meta_ready;
      cfg_hs        = cfg_valid && cfg_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
      end else if (state == HOLD && state_nxt == DRAIN) begin
         drain_cnt <= DCW'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN && drain_cnt != '0) begin
         drain_cnt <= drain_cnt - DCW'(1);
      end
   end

   // Once a valid has been shown downstream the gate stays open until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_busy <= 1'b0;
      end else if (meta_hs) begin
         meta_busy <= 1'b0;
      end else if (dn_meta_valid) begin
         meta_busy <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         write_cnt <= '0;
      end else begin
         wr_en <= cfg_hs;
         if (cfg_hs) begin
            wr_addr   <= cfg_addr;
            wr_data   <= cfg_data;
            write_cnt <= write_cnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state != RUN) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pg_table_loader.sv
// Randomized bench for pg_table_loader against a cycle-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_pg_table_loader;

   localparam int D  = 8;
   localparam int AW = pg_table_loader_pkg::RULE_AWIDTH;
   localparam int DW = pg_table_loader_pkg::RULE_PG_WIDTH;

   logic          clk;
   logic          rst_n;
   logic          cfg_valid, cfg_ready, cfg_last;
   logic [AW-1:0] cfg_addr, wr_addr;
   logic [DW-1:0] cfg_data, wr_data;
   logic          up_meta_valid, up_meta_ready, dn_meta_valid, dn_meta_ready;
   logic          wr_en, busy;
   logic [31:0]   write_cnt, stall_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit cmp_en = 0;
   bit rand_done = 0;

   int            wq_cyc[$];
   logic [AW-1:0] wq_addr[$];
   logic [DW-1:0] wq_data[$];
   logic [DW-1:0] exp_data[$];
   int            hs_cyc = -1;

   pg_table_loader #(.DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_last(cfg_last),
      .up_meta_valid(up_meta_valid), .up_meta_ready(up_meta_ready),
      .dn_meta_valid(dn_meta_valid), .dn_meta_ready(dn_meta_ready),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
      .busy(busy), .write_cnt(write_cnt), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: phase 0 open traffic, 1 waiting for meta to settle,
   // 2 counting quiet cycles, 3 accepting entries.
   int            m_phase;
   bit            m_pending;
   int            m_quiet;
   bit            m_wr_en;
   logic [AW-1:0] m_wr_addr;
   logic [DW-1:0] m_wr_data;
   logic [31:0]   m_wcnt, m_scnt;

   function automatic bit m_open();
      return (m_phase == 0) || m_pending;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit open, mhs;
      if (!rst_n) begin
         m_phase = 0; m_pending = 0; m_quiet = 0; m_wr_en = 0;
         m_wr_addr = '0; m_wr_data = '0; m_wcnt = '0; m_scnt = '0;
      end else begin
         open = m_open();
         mhs  = up_meta_valid && dn_meta_ready && open;
         if (m_phase != 0) m_scnt = m_scnt + 1;
         m_wr_en = 0;
         case (m_phase)
            0: if (cfg_valid) m_phase = 1;
            1: if (!m_pending && !mhs) begin m_phase = 2; m_quiet = D; end
            2: begin m_quiet--; if (m_quiet == 0) m_phase = 3; end
            default: if (cfg_valid) begin
               m_wr_en = 1; m_wr_addr = cfg_addr; m_wr_data = cfg_data;
               m_wcnt = m_wcnt + 1;
               if (cfg_last) m_phase = 0;
            end
         endcase
         if (mhs) m_pending = 0;
         else if (up_meta_valid && open) m_pending = 1;
      end
   end

   always @(negedge clk) begin
      bit open;
      if (cmp_en && rst_n) begin
         open = m_open();
         checkOutput("dn_meta_valid", dn_meta_valid, up_meta_valid && open);
         checkOutput("up_meta_ready", up_meta_ready, dn_meta_ready && open);
         checkOutput("cfg_ready", cfg_ready, m_phase == 3);
         checkOutput("busy", busy, m_phase != 0);
         checkOutput("wr_en", wr_en, m_wr_en);
         checkOutput("wr_addr", wr_addr, m_wr_addr);
         checkOutput("wr_data", wr_data, m_wr_data);
         checkOutput("write_cnt", write_cnt, m_wcnt);
         checkOutput("stall_cnt", stall_cnt, m_scnt);
      end
      if (wr_en) begin
         wq_cyc.push_back(cyc); wq_addr.push_back(wr_addr); wq_data.push_back(wr_data);
      end
      if (dn_meta_valid && dn_meta_ready) hs_cyc = cyc;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearQueues();
      wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); exp_data.delete();
   endtask

   task automatic waitAccept();
      int budget = 0;
      forever begin
         @(negedge clk);
         if (cfg_ready) break;
         budget++;
         if (budget > 300) begin
            checks++; errors++;
            $display("[TB] FAIL cfg_accept_timeout actual=no_ready required=ready cycle=%0d", cyc);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int n, input logic [AW-1:0] base, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            cfg_valid = 1'b0;
            tick($urandom_range(1, 3));
         end
         cfg_valid = 1'b1;
         cfg_addr  = base + AW'(i);
         cfg_data  = DW'($urandom);
         cfg_last  = (i == n - 1);
         exp_data.push_back(cfg_data);
         waitAccept();
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0;
      up_meta_valid = 1'b1; dn_meta_ready = 1'b1;
      cmp_en = 1'b1;
      tick(3);
      checkOutput("rst_dn_meta_valid", dn_meta_valid, 1);
      checkOutput("rst_up_meta_ready", up_meta_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_cfg_ready", cfg_ready, 0);
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_write_cnt", write_cnt, 0);
      up_meta_valid = 1'b0; dn_meta_ready = 1'b0;
      rst_n = 1'b1;
      tick(2);

      // Idle single write
      clearQueues();
      t0 = cyc;
      cfg_valid = 1'b1; cfg_addr = AW'(10'h0A5); cfg_data = DW'(16'h1234); cfg_last = 1'b1;
      waitAccept();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      tick(2);
      checkOutput("idle_wr_count", wq_cyc.size(), 1);
      if (wq_cyc.size() > 0) begin
         checkOutput("idle_latency", wq_cyc[0] - t0, 3 + D);
         checkOutput("idle_addr", wq_addr[0], 32'h0A5);
         checkOutput("idle_data", wq_data[0], 32'h1234);
      end
      checkOutput("idle_write_cnt", write_cnt, 1);
      checkOutput("idle_stall_cnt", stall_cnt, D + 2);

      // Request while a meta is held in the port group
      clearQueues();
      hs_cyc = -1;
      up_meta_valid = 1'b1; dn_meta_ready = 1'b0;
      tick(2);
      fork
         begin
            tick(8);
            dn_meta_ready = 1'b1;
            tick(1);
            dn_meta_ready = 1'b0; up_meta_valid = 1'b0;
         end
         begin
            cfg_valid = 1'b1; cfg_addr = AW'(3); cfg_data = DW'(16'hBEEF); cfg_last = 1'b1;
            waitAccept();
            cfg_valid = 1'b0; cfg_last = 1'b0;
         end
      join
      tick(2);
      checkOutput("midpkt_wr_count", wq_cyc.size(), 1);
      if (wq_cyc.size() > 0) checkOutput("midpkt_latency", wq_cyc[0] - hs_cyc, D + 3);

      // Traffic blocked until the last entry lands
      cfg_valid = 1'b1; cfg_addr = AW'(20); cfg_data = DW'(16'h0101); cfg_last = 1'b0;
      tick(3);
      up_meta_valid = 1'b1; dn_meta_ready = 1'b1;
      waitAccept();
      checkOutput("block_dn_valid", dn_meta_valid, 0);
      checkOutput("block_up_ready", up_meta_ready, 0);
      cfg_addr = AW'(21); cfg_data = DW'(16'h0202); cfg_last = 1'b1;
      waitAccept();
      cfg_valid = 1'b0; cfg_last = 1'b0;
      checkOutput("reopen_dn_valid", dn_meta_valid, 1);
      checkOutput("reopen_up_ready", up_meta_ready, 1);
      tick(1);
      up_meta_valid = 1'b0; dn_meta_ready = 1'b0;

      // Burst of 8 from a clean reset
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      clearQueues();
      applyStimulus(8, '0, 1'b0);
      tick(2);
      checkOutput("burst_wr_count", wq_cyc.size(), 8);
      if (wq_cyc.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("burst_addr", wq_addr[i], i);
            checkOutput("burst_data", wq_data[i], exp_data[i]);
            checkOutput("burst_consecutive", wq_cyc[i] - wq_cyc[0], i);
         end
      end
      checkOutput("burst_write_cnt", write_cnt, 8);

      // Reset in the middle of a batch
      for (int i = 0; i < 3; i++) begin
         cfg_valid = 1'b1; cfg_addr = AW'(40 + i); cfg_data = DW'($urandom); cfg_last = 1'b0;
         waitAccept();
      end
      checkOutput("pre_rst_wr_en", wr_en, 1);
      rst_n = 1'b0; cfg_valid = 1'b0;
      up_meta_valid = 1'b1; dn_meta_ready = 1'b0;
      #1;
      checkOutput("midrst_wr_en", wr_en, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_cfg_ready", cfg_ready, 0);
      checkOutput("midrst_write_cnt", write_cnt, 0);
      checkOutput("midrst_stall_cnt", stall_cnt, 0);
      checkOutput("midrst_dn_valid", dn_meta_valid, 1);
      dn_meta_ready = 1'b1;
      #1;
      checkOutput("midrst_up_ready", up_meta_ready, 1);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      up_meta_valid = 1'b0; dn_meta_ready = 1'b0;
      tick(1);

      // Counter wrap
      force dut.write_cnt = 32'hFFFF_FFFF;
      m_wcnt = 32'hFFFF_FFFF;
      #1;
      release dut.write_cnt;
      applyStimulus(2, AW'(100), 1'b0);
      tick(2);
      checkOutput("wrap_write_cnt", write_cnt, 32'h0000_0001);

      // Random traffic with random batches
      rand_done = 1'b0;
      fork
         while (!rand_done) begin
            bit acc;
            @(negedge clk);
            acc = up_meta_valid && up_meta_ready;
            @(posedge clk);
            #1;
            if (acc || !up_meta_valid) up_meta_valid = ($urandom_range(0, 2) != 0);
            dn_meta_ready = ($urandom_range(0, 3) == 0);
         end
         begin
            for (int b = 0; b < 14; b++) begin
               if ($urandom_range(0, 1) == 1) begin
                  cfg_valid = 1'b1; cfg_last = 1'b0;
                  tick(1);
                  cfg_valid = 1'b0;
                  tick($urandom_range(1, D + 3));
               end
               applyStimulus($urandom_range(1, 5), AW'($urandom), 1'b1);
               tick($urandom_range(0, 3));
            end
            rand_done = 1'b1;
         end
      join
      up_meta_valid = 1'b0; dn_meta_ready = 1'b0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
